// File: rtl/up_dn_counter.sv
// ----------------------------------------------------------------------------
// up_dn_counter
//
// Loadable up/down counter with limit flags. Control priority is fixed:
// Load, then Down, then Up. By default the count saturates at 0 and at
// 2^WIDTH-1. If UP_DN_COUNTER_WRAP_EN is defined, it wraps at both limits
// instead. Load and priority behave the same in both builds.
//
// Parameters
//   WIDTH   : counter / load-value width (range 0 .. 2^WIDTH-1)
//
// Ports
//   CLK     : clock; all state updates on the rising edge
//   RST     : asynchronous active-low reset, clears Counter
//   IN      : value loaded when Load is high
//   Load    : synchronous load request (highest priority)
//   Up      : increment request (lowest priority)
//   Down    : decrement request (beats Up)
//   Counter : registered count value
//   High    : Counter == 2^WIDTH-1 (combinational decode)
//   Low     : Counter == 0         (combinational decode)
// ----------------------------------------------------------------------------
module up_dn_counter #(
   parameter int WIDTH = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] IN,
   input  logic             Load,
   input  logic             Up,
   input  logic             Down,
   output logic [WIDTH-1:0] Counter,
   output logic             High,
   output logic             Low
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_MIN = '0;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_nxt;

   // Flags decode the register directly, so they line up with Counter in the
   // same cycle and need no extra stage.
   always_comb begin
      High = (Counter == CNT_MAX);
      Low  = (Counter == CNT_MIN);
   end

   // The limit checks come before the +/-1. That way a WIDTH-bit result
   // never carries or borrows into Counter in the saturating build.
   always_comb begin
      cnt_nxt = Counter;
      if (Load) begin
         cnt_nxt = IN;
      end else if (Down) begin
         if (!Low) begin
            cnt_nxt = Counter - CNT_ONE;
         end else begin
`ifdef UP_DN_COUNTER_WRAP_EN
            cnt_nxt = CNT_MAX;
`else
            cnt_nxt = CNT_MIN;
`endif
         end
      end else if (Up) begin
         if (!High) begin
            cnt_nxt = Counter + CNT_ONE;
         end else begin
`ifdef UP_DN_COUNTER_WRAP_EN
            cnt_nxt = CNT_MIN;
`else
            cnt_nxt = CNT_MAX;
`endif
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         Counter <= CNT_MIN;
      end else begin
         Counter <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_up_dn_counter.sv
module tb_up_dn_counter;

   localparam int WIDTH = 5;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             CLK = 1'b0;
   logic             RST;
   logic [WIDTH-1:0] IN;
   logic             Load, Up, Down;
   logic [WIDTH-1:0] Counter;
   logic             High, Low;

   int vectors     = 0;
   int miscompares = 0;
   int model       = 0;

   up_dn_counter #(.WIDTH(WIDTH)) dut (
      .CLK(CLK), .RST(RST), .IN(IN), .Load(Load), .Up(Up), .Down(Down),
      .Counter(Counter), .High(High), .Low(Low)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the value as a plain integer.
   // Wrap or saturation is applied arithmetically at the range limits.
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         model <= 0;
      end else if (Load) begin
         model <= int'(IN);
      end else if (Down) begin
`ifdef UP_DN_COUNTER_WRAP_EN
         model <= (model == 0) ? MAXV : model - 1;
`else
         model <= (model == 0) ? 0 : model - 1;
`endif
      end else if (Up) begin
`ifdef UP_DN_COUNTER_WRAP_EN
         model <= (model == MAXV) ? 0 : model + 1;
`else
         model <= (model == MAXV) ? MAXV : model + 1;
`endif
      end
   end

   // Continuous compare at the falling edge, away from the update edge.
   always @(negedge CLK) begin
      check("counter", int'(Counter), model);
      check("high", int'(High), int'(model == MAXV));
      check("low", int'(Low), int'(model == 0));
   end

   task automatic drive(input logic ld, input logic up, input logic dn, input int val);
      Load = ld; Up = up; Down = dn; IN = WIDTH'(val);
   endtask

   // Waits n rising edges and returns at the following falling edge.
   task automatic edges(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      RST = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 25);
      #1;
      check("rst_counter", int'(Counter), 0);
      check("rst_low", int'(Low), 1);
      check("rst_high", int'(High), 0);

      @(negedge CLK);
      RST = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 25);
      edges(1);
      check("load_wins", int'(Counter), 25);

      drive(1'b0, 1'b1, 1'b1, 0);
      edges(25);
`ifndef UP_DN_COUNTER_WRAP_EN
      check("updn_reach0", int'(Counter), 0);
      check("updn_low", int'(Low), 1);
`endif
      edges(2);
`ifndef UP_DN_COUNTER_WRAP_EN
      check("updn_hold0", int'(Counter), 0);
`endif

      drive(1'b0, 1'b1, 1'b0, 0);
      edges(31);
`ifndef UP_DN_COUNTER_WRAP_EN
      check("up_reach_max", int'(Counter), 31);
      check("up_high", int'(High), 1);
`endif
      edges(4);
`ifndef UP_DN_COUNTER_WRAP_EN
      check("up_hold_max", int'(Counter), 31);
`endif

      drive(1'b0, 1'b0, 1'b1, 0);
      edges(5);
`ifndef UP_DN_COUNTER_WRAP_EN
      check("down5", int'(Counter), 26);
`endif
      check("down5_high", int'(High), int'(Counter == 5'd31));

      drive(1'b1, 1'b0, 1'b0, 10);
      edges(3);
      check("load_hold", int'(Counter), 10);

      // Reset asserted between clock edges must clear the count at once.
      drive(1'b0, 1'b1, 1'b0, 0);
      edges(2);
      check("count_12", int'(Counter), 12);
      @(posedge CLK);
      #2;
      RST = 1'b0;
      #1;
      check("async_rst", int'(Counter), 0);
      check("async_rst_low", int'(Low), 1);
      @(negedge CLK);
      RST = 1'b1;

`ifdef UP_DN_COUNTER_WRAP_EN
      drive(1'b1, 1'b0, 1'b0, 0);
      edges(1);
      drive(1'b0, 1'b0, 1'b1, 0);
      edges(1);
      check("wrap_down", int'(Counter), 31);
      drive(1'b0, 1'b1, 1'b0, 0);
      edges(1);
      check("wrap_up", int'(Counter), 0);
`else
      drive(1'b1, 1'b0, 1'b0, 31);
      edges(1);
      check("load_max_high", int'(High), 1);
      drive(1'b1, 1'b1, 1'b0, 0);
      edges(1);
      check("load_zero", int'(Counter), 0);
`endif

      // Random phase, weighted so the runs reach both limits often.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
               ($urandom_range(0, 2) == 0), int'($urandom_range(0, MAXV)));
         if ($urandom_range(0, 99) == 0) begin
            #2 RST = 1'b0;
            #1 RST = 1'b1;
         end
         @(negedge CLK);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
